rx_frame_dispatch: RTL and testbench

Frame-level controller that sits behind the serial receiver's 32-bit word output in the `aclk` domain. It parses a header word, sequences the payload words of each frame to one of `NUM_DEST` consumers over valid/ready, and optionally checks a trailing XOR checksum. Frames that are malformed or addressed to nothing are dropped and counted.

---
 rtl/rx_frame_pkg.sv | 23 ++
 rtl/rx_frame_out_stage.sv | 53 +++++
 rtl/rx_frame_dispatch.sv | 150 +++++++++++++++
 tb/tb_rx_frame_dispatch.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_frame_pkg.sv
// Shared state encoding, header field layout and counter width for rx_frame_dispatch.
// The CHECK state exists only when RX_FRAME_CSUM_EN is defined.
package rx_frame_pkg;

`ifdef RX_FRAME_CSUM_EN
    typedef enum logic [1:0] {ST_IDLE, ST_PAYLOAD, ST_DROP, ST_CHECK} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_PAYLOAD, ST_DROP} state_t;
`endif

    localparam int SYNC_HI = 31;
    localparam int SYNC_LO = 24;
    localparam int DEST_HI = 23;
    localparam int DEST_LO = 20;
    localparam int LEN_HI  = 15;
    localparam int LEN_LO  = 0;
    localparam int DEST_W  = DEST_HI - DEST_LO + 1;
    localparam int LEN_W   = LEN_HI - LEN_LO + 1;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
    localparam int         ERR_CNT_W         = 16;

endpackage

// File: rtl/rx_frame_out_stage.sv
// One-entry output register: holds a payload word, its destination and last flag
// until the addressed consumer takes it; drives one-hot out_valid.
module rx_frame_out_stage
    import rx_frame_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_DEST = 4
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                load,
    input  logic [DATA_W-1:0]   load_data,
    input  logic [DEST_W-1:0]   load_dest,
    input  logic                load_last,
    input  logic [NUM_DEST-1:0] out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [NUM_DEST-1:0] out_valid,
    output logic                out_last,
    output logic                full,
    output logic                pop
);

    logic [DEST_W-1:0] dest;

    always_comb begin
        // NOTE: assign a default before any conditional write so no latch is inferred.
        out_valid = '0;
        for (int i = 0; i < NUM_DEST; i++) begin
            if (full && int'(dest) == i) out_valid[i] = 1'b1;
        end
    end

    // Only the addressed consumer's ready can release the entry.
    assign pop = |(out_valid & out_ready);

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            full     <= 1'b0;
            dest     <= '0;
            out_data <= '0;
            out_last <= 1'b0;
        end else if (load) begin
            full     <= 1'b1;
            dest     <= load_dest;
            out_data <= load_data;
            out_last <= load_last;
        end else if (pop) begin
            full     <= 1'b0;
        end
    end

endmodule

// File: rtl/rx_frame_dispatch.sv
// Frame parser/dispatcher: header decode, payload routing to NUM_DEST consumers, error counting.
// Define RX_FRAME_CSUM_EN to add a trailing XOR checksum word to every frame.
module rx_frame_dispatch
    import rx_frame_pkg::*;
#(
    parameter int         DATA_W    = 32,
    parameter int         NUM_DEST  = 4,
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE,
    parameter int         MAX_LEN   = 256
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [DATA_W-1:0]    in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic [NUM_DEST-1:0]  out_valid,
    input  logic [NUM_DEST-1:0]  out_ready,
    output logic                 out_last,
    output logic                 frame_done,
    output logic                 frame_err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 busy
);

    state_t            state;
    logic [LEN_W-1:0]  remaining;
    logic [DEST_W-1:0] dest_q;
    logic              stage_full;
    logic              stage_pop;
    logic              accept;
    logic              err_event;
    logic              hdr_frame_ok;
    logic              hdr_dest_ok;
    logic [7:0]        hdr_sync;
    logic [DEST_W-1:0] hdr_dest;
    logic [LEN_W-1:0]  hdr_len;
`ifdef RX_FRAME_CSUM_EN
    logic [DATA_W-1:0] acc;
`endif

    assign hdr_sync     = in_data[SYNC_HI:SYNC_LO];
    assign hdr_dest     = in_data[DEST_HI:DEST_LO];
    assign hdr_len      = in_data[LEN_HI:LEN_LO];
    assign hdr_frame_ok = (hdr_sync == SYNC_BYTE) && (hdr_len != '0) && (int'(hdr_len) <= MAX_LEN);
    assign hdr_dest_ok  = int'(hdr_dest) < NUM_DEST;

    // Only PAYLOAD can be stalled; a header may arrive while the last word still waits.
    always_comb begin
        in_ready = 1'b0;
        if (aresetn) in_ready = (state == ST_PAYLOAD) ? (!stage_full || stage_pop) : 1'b1;
    end

    assign accept = in_valid && in_ready;
    assign busy   = (state != ST_IDLE) || stage_full;

    always_comb begin
        err_event = 1'b0;
        if (accept) begin
            if (state == ST_IDLE) err_event = !(hdr_frame_ok && hdr_dest_ok);
`ifdef RX_FRAME_CSUM_EN
            if (state == ST_CHECK) err_event = (in_data != acc);
`endif
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state      <= ST_IDLE;
            remaining  <= '0;
            dest_q     <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            err_count  <= '0;
`ifdef RX_FRAME_CSUM_EN
            acc        <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            frame_err  <= err_event;
            if (err_event && err_count != '1) err_count <= err_count + 1'b1;
            if (accept) begin
                unique case (state)
                    ST_IDLE: begin
                        remaining <= hdr_len;
                        if (hdr_frame_ok) begin
                            if (hdr_dest_ok) begin
                                dest_q <= hdr_dest;
                                state  <= ST_PAYLOAD;
`ifdef RX_FRAME_CSUM_EN
                                acc    <= '0;
`endif
                            end else begin
                                state  <= ST_DROP;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        remaining <= remaining - 1'b1;
`ifdef RX_FRAME_CSUM_EN
                        acc <= acc ^ in_data;
                        if (remaining == LEN_W'(1)) state <= ST_CHECK;
`else
                        if (remaining == LEN_W'(1)) begin
                            state      <= ST_IDLE;
                            frame_done <= 1'b1;
                        end
`endif
                    end
                    ST_DROP: begin
`ifdef RX_FRAME_CSUM_EN
                        // remaining reaches zero with the trailer still to be swallowed
                        if (remaining == '0) state <= ST_IDLE;
                        else                 remaining <= remaining - 1'b1;
`else
                        remaining <= remaining - 1'b1;
                        if (remaining == LEN_W'(1)) state <= ST_IDLE;
`endif
                    end
`ifdef RX_FRAME_CSUM_EN
                    ST_CHECK: begin
                        frame_done <= 1'b1;
                        state      <= ST_IDLE;
                    end
`endif
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    rx_frame_out_stage #(
        .DATA_W   (DATA_W),
        .NUM_DEST (NUM_DEST)
    ) u_out_stage (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .load      (accept && state == ST_PAYLOAD),
        .load_data (in_data),
        .load_dest (dest_q),
        .load_last (remaining == LEN_W'(1)),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .full      (stage_full),
        .pop       (stage_pop)
    );

endmodule

// File: tb/tb_rx_frame_dispatch.sv
// Self-checking bench for rx_frame_dispatch: frame-level reference model and scoreboard.
// Follows RX_FRAME_CSUM_EN so the same bench covers both builds.
module tb_rx_frame_dispatch;

    localparam int NUM_DEST = 4;
    localparam int MAX_LEN  = 256;
    localparam int TIMEOUT  = 1000;

    typedef struct packed {
        logic [NUM_DEST-1:0] valid;
        logic [31:0]         data;
        logic                last;
    } beat_t;

    logic                aclk = 1'b0;
    logic                aresetn = 1'b0;
    logic [31:0]         in_data = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [31:0]         out_data;
    logic [NUM_DEST-1:0] out_valid;
    logic [NUM_DEST-1:0] out_ready = '0;
    logic                out_last;
    logic                frame_done;
    logic                frame_err;
    logic [15:0]         err_count;
    logic                busy;

    int          pass_cnt = 0;
    int          total = 0;
    int          done_seen = 0;
    int          err_seen = 0;
    int          onehot_bad = 0;
    int          hold_bad = 0;
    int          cyc = 0;
    int          exp_done = 0;
    int          exp_err_pulses = 0;
    logic [15:0] exp_err_cnt = '0;
    bit          stalled = 1'b0;
    bit          rand_ready = 1'b0;
    logic [NUM_DEST-1:0] ready_fixed = '1;

    beat_t       exp_q[$];
    beat_t       obs_q[$];
    int          obs_cyc[$];
    logic [31:0] pl_q[$];

    rx_frame_dispatch dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .err_count  (err_count),
        .busy       (busy)
    );

    always #5 aclk = ~aclk;

    // Observer: samples one time unit before each rising edge, records handshakes and pulses.
    beat_t prev_beat = '0;
    bit    prev_hs = 1'b0;
    always @(negedge aclk) begin
        #4;
        cyc++;
        if (!aresetn) begin
            prev_beat = '0;
            prev_hs   = 1'b0;
        end else begin
            if ($countones(out_valid) > 1) onehot_bad++;
            if (prev_beat.valid != '0 && !prev_hs && {out_valid, out_data, out_last} !== prev_beat) hold_bad++;
            prev_hs   = |(out_valid & out_ready);
            prev_beat = {out_valid, out_data, out_last};
            if (prev_hs) begin
                obs_q.push_back(prev_beat);
                obs_cyc.push_back(cyc);
            end
            if (frame_done === 1'b1) done_seen++;
            if (frame_err === 1'b1) err_seen++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic apply_ready();
        out_ready = rand_ready ? NUM_DEST'($urandom) : ready_fixed;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge aclk);
            apply_ready();
        end
    endtask

    task automatic send_word(input logic [31:0] d);
        bit took = 1'b0;
        if (stalled) return;
        in_data  = d;
        in_valid = 1'b1;
        for (int n = 0; n < TIMEOUT && !took; n++) begin
            #1;
            took = in_ready;
            @(negedge aclk);
            apply_ready();
        end
        in_valid = 1'b0;
        if (!took) begin
            total++;
            $display("FAIL send_timeout: in_ready stayed %b for %0d cycles, expected 1", in_ready, TIMEOUT);
            stalled = 1'b1;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        if (stalled) return;
        #1;
        while (busy !== 1'b0 && n < TIMEOUT) begin
            step(1);
            #1;
            n++;
        end
        step(2);
        if (n >= TIMEOUT) begin
            total++;
            $display("FAIL drain_timeout: busy=%b after %0d cycles, expected 0", busy, n);
            stalled = 1'b1;
        end
    endtask

    // ---------------- reference model ----------------
    task automatic note_err();
        exp_err_pulses++;
        if (exp_err_cnt != 16'hFFFF) exp_err_cnt++;
    endtask

    function automatic logic [31:0] pl_xor();
        logic [31:0] x = '0;
        foreach (pl_q[i]) x ^= pl_q[i];
        return x;
    endfunction

    // Sends a whole frame (header, payload from pl_q, trailer if compiled in) and
    // records what the consumers and counters should see.
    task automatic send_frame(input logic [31:0] hdr, input logic [31:0] trl);
        int    len = int'(hdr[15:0]);
        int    dest = int'(hdr[23:20]);
        beat_t b;
        send_word(hdr);
        if (hdr[31:24] != 8'hA5 || len == 0 || len > MAX_LEN) begin
            note_err();
            return;
        end
        if (dest >= NUM_DEST) begin
            note_err();
            for (int i = 0; i < len; i++) send_word(pl_q[i]);
`ifdef RX_FRAME_CSUM_EN
            send_word(trl);
`endif
            return;
        end
        for (int i = 0; i < len; i++) begin
            send_word(pl_q[i]);
            b.valid = NUM_DEST'(1 << dest);
            b.data  = pl_q[i];
            b.last  = (i == len - 1);
            exp_q.push_back(b);
        end
`ifdef RX_FRAME_CSUM_EN
        send_word(trl);
        if (trl != pl_xor()) note_err();
`else
        if (trl == 32'hFFFF_FFFF) pl_q.delete(); // trailer unused without checksum
`endif
        exp_done++;
    endtask

    function automatic int stream_diff();
        int n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (obs_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] got[8];
        string       nm[8];
        aresetn = 1'b0;
        step(3);
        #1;
        got = '{32'(in_ready), 32'(out_valid), out_data, 32'(out_last),
                32'(frame_done), 32'(frame_err), 32'(err_count), 32'(busy)};
        nm  = '{"in_ready", "out_valid", "out_data", "out_last",
                "frame_done", "frame_err", "err_count", "busy"};
        for (int i = 0; i < 8; i++) begin
            total++;
            if (got[i] !== 32'd0) $display("FAIL reset_%s: got %h expected 0", nm[i], got[i]);
            else pass_cnt++;
        end
        aresetn = 1'b1;
    endtask

    task automatic test_basic();
        int n;
        pl_q.delete();
        for (int i = 0; i < 3; i++) pl_q.push_back($urandom);
        send_frame(32'hA510_0003, pl_xor());
        wait_idle();
        n = obs_q.size();
        total++;
        if (n !== 3) $display("FAIL basic_words: got %0d words expected 3", n);
        else pass_cnt++;
        total++;
        if (stream_diff() !== -1) $display("FAIL basic_stream: first bad index %0d", stream_diff());
        else pass_cnt++;
        total++;
        if (n >= 3 && obs_cyc[n-1] - obs_cyc[n-3] !== 2)
            $display("FAIL basic_throughput: got span %0d cycles expected 2", obs_cyc[n-1] - obs_cyc[n-3]);
        else pass_cnt++;
        total++;
        if (done_seen !== exp_done) $display("FAIL basic_done: got %0d pulses expected %0d", done_seen, exp_done);
        else pass_cnt++;
        total++;
        if (err_count !== exp_err_cnt) $display("FAIL basic_err_count: got %0d expected %0d", err_count, exp_err_cnt);
        else pass_cnt++;
    endtask

    task automatic test_bad_sync();
        send_frame(32'h5A00_0002, 32'h0);
        step(2);
        total++;
        if (err_count !== exp_err_cnt) $display("FAIL sync_err_count: got %0d expected %0d", err_count, exp_err_cnt);
        else pass_cnt++;
        total++;
        if (err_seen !== exp_err_pulses) $display("FAIL sync_err_pulse: got %0d expected %0d", err_seen, exp_err_pulses);
        else pass_cnt++;
        pl_q.delete();
        pl_q.push_back($urandom);
        send_frame(32'hA500_0001, pl_xor());
        wait_idle();
        total++;
        if (obs_q.size() !== exp_q.size() || stream_diff() !== -1)
            $display("FAIL sync_next_frame: got %0d words expected %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_drop();
        pl_q.delete();
        pl_q.push_back($urandom);
        pl_q.push_back($urandom);
        send_frame(32'hA550_0002, $urandom);
        pl_q.delete();
        pl_q.push_back($urandom);
        send_frame(32'hA520_0001, pl_xor());
        wait_idle();
        total++;
        if (obs_q.size() !== exp_q.size() || stream_diff() !== -1)
            $display("FAIL drop_stream: got %0d words expected %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        total++;
        if (err_count !== exp_err_cnt) $display("FAIL drop_err_count: got %0d expected %0d", err_count, exp_err_cnt);
        else pass_cnt++;
        total++;
        if (done_seen !== exp_done) $display("FAIL drop_done: got %0d expected %0d", done_seen, exp_done);
        else pass_cnt++;
    endtask

    task automatic test_len_bounds();
        pl_q.delete();
        for (int i = 0; i < MAX_LEN; i++) pl_q.push_back($urandom);
        send_frame(32'hA530_0100, pl_xor());
        send_frame(32'hA500_0000, 32'h0);
        send_frame(32'hA510_0101, 32'h0);
        wait_idle();
        total++;
        if (obs_q.size() !== exp_q.size() || stream_diff() !== -1)
            $display("FAIL bounds_stream: got %0d words expected %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        total++;
        if (err_count !== exp_err_cnt) $display("FAIL bounds_err_count: got %0d expected %0d", err_count, exp_err_cnt);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [31:0] w[6];
        beat_t       b;
        for (int i = 0; i < 6; i++) w[i] = $urandom;
        pl_q.delete();
        for (int i = 0; i < 6; i++) pl_q.push_back(w[i]);
        send_word(32'hA500_0006);
        send_word(w[0]);
        send_word(w[1]);
        ready_fixed = 4'b1110;
        apply_ready();
        in_data  = w[2];
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            total++;
            if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b expected 0 (cycle %0d)", in_ready, c);
            else pass_cnt++;
            total++;
            if (out_data !== w[1] || out_valid !== 4'b0001)
                $display("FAIL bp_hold: got %h/%b expected %h/0001", out_data, out_valid, w[1]);
            else pass_cnt++;
            @(negedge aclk);
            apply_ready();
        end
        in_valid    = 1'b0;
        ready_fixed = '1;
        apply_ready();
        for (int i = 2; i < 6; i++) send_word(w[i]);
`ifdef RX_FRAME_CSUM_EN
        send_word(pl_xor());
`endif
        for (int i = 0; i < 6; i++) begin
            b.valid = 4'b0001;
            b.data  = w[i];
            b.last  = (i == 5);
            exp_q.push_back(b);
        end
        exp_done++;
        wait_idle();
        total++;
        if (obs_q.size() !== exp_q.size() || stream_diff() !== -1)
            $display("FAIL bp_stream: got %0d words expected %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
    endtask

`ifdef RX_FRAME_CSUM_EN
    task automatic test_checksum();
        pl_q.delete();
        pl_q.push_back(32'h1);
        pl_q.push_back(32'h2);
        send_frame(32'hA500_0002, 32'h3);
        wait_idle();
        total++;
        if (err_seen !== exp_err_pulses || done_seen !== exp_done)
            $display("FAIL csum_good: got err %0d done %0d expected %0d %0d", err_seen, done_seen, exp_err_pulses, exp_done);
        else pass_cnt++;
        send_frame(32'hA500_0002, 32'h4);
        wait_idle();
        total++;
        if (err_seen !== exp_err_pulses || done_seen !== exp_done)
            $display("FAIL csum_bad: got err %0d done %0d expected %0d %0d", err_seen, done_seen, exp_err_pulses, exp_done);
        else pass_cnt++;
    endtask
`endif

    task automatic test_mid_reset();
        logic [31:0] w0 = $urandom;
        logic [31:0] w1 = $urandom;
        logic [31:0] got[8];
        beat_t       b;
        ready_fixed = '1;
        send_word(32'hA520_0004);
        send_word(w0);
        send_word(w1);
        b.valid = 4'b0100;
        b.data  = w0;
        b.last  = 1'b0;
        exp_q.push_back(b);
        aresetn = 1'b0;
        step(1);
        #1;
        got = '{32'(in_ready), 32'(out_valid), out_data, 32'(out_last),
                32'(frame_done), 32'(frame_err), 32'(err_count), 32'(busy)};
        for (int i = 0; i < 8; i++) begin
            total++;
            if (got[i] !== 32'd0) $display("FAIL midreset_out%0d: got %h expected 0", i, got[i]);
            else pass_cnt++;
        end
        aresetn     = 1'b1;
        exp_err_cnt = '0;
        pl_q.delete();
        pl_q.push_back($urandom);
        send_frame(32'hA510_0001, pl_xor());
        wait_idle();
        total++;
        if (obs_q.size() !== exp_q.size() || stream_diff() !== -1)
            $display("FAIL midreset_stream: got %0d words expected %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        total++;
        if (done_seen !== exp_done) $display("FAIL midreset_done: got %0d expected %0d", done_seen, exp_done);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int          kind;
        int          len;
        logic [7:0]  s;
        logic [31:0] hdr;
        logic [31:0] trl;
        rand_ready = 1'b1;
        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 9);
            pl_q.delete();
            len = 0;
            if (kind == 0) begin
                s = 8'($urandom_range(0, 255));
                if (s == 8'hA5) s = 8'h00;
                hdr = {s, 24'($urandom)};
            end else if (kind == 1) begin
                hdr = {8'hA5, 4'($urandom_range(0, 3)), 4'h0,
                       ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(257, 65535))};
            end else if (kind == 2) begin
                len = $urandom_range(1, 6);
                hdr = {8'hA5, 4'($urandom_range(4, 15)), 4'($urandom), 16'(len)};
            end else begin
                len = $urandom_range(1, 8);
                hdr = {8'hA5, 4'($urandom_range(0, 3)), 4'($urandom), 16'(len)};
            end
            for (int i = 0; i < len; i++) pl_q.push_back($urandom);
            trl = ($urandom_range(0, 3) == 0) ? $urandom : pl_xor();
            send_frame(hdr, trl);
        end
        wait_idle();
        rand_ready = 1'b0;
        total++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL rand_count: got %0d words expected %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        total++;
        if (stream_diff() !== -1) $display("FAIL rand_stream: first bad index %0d expected none", stream_diff());
        else pass_cnt++;
        total++;
        if (done_seen !== exp_done) $display("FAIL rand_done: got %0d expected %0d", done_seen, exp_done);
        else pass_cnt++;
        total++;
        if (err_seen !== exp_err_pulses) $display("FAIL rand_err_pulses: got %0d expected %0d", err_seen, exp_err_pulses);
        else pass_cnt++;
        total++;
        if (err_count !== exp_err_cnt) $display("FAIL rand_err_count: got %0d expected %0d", err_count, exp_err_cnt);
        else pass_cnt++;
        total++;
        if (onehot_bad !== 0) $display("FAIL onehot: got %0d multi-hot samples expected 0", onehot_bad);
        else pass_cnt++;
        total++;
        if (hold_bad !== 0) $display("FAIL hold: got %0d unstable samples expected 0", hold_bad);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_sync();
        test_drop();
        test_len_bounds();
        test_backpressure();
`ifdef RX_FRAME_CSUM_EN
        test_checksum();
`endif
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
